// File: rtl/rr_grant_arb_if.sv
// rr_grant_arb_if: request/grant bundle between the requesters, the
// round-robin arbiter and the downstream one-hot mux stage.
//   req      requester -> arbiter   per-requester request level
//   gnt      arbiter   -> mux       registered one-hot grant (mux sel)
//   gnt_idx  arbiter   -> mux       registered binary index of gnt
//   gnt_vld  arbiter   -> mux       grant presented downstream
//   gnt_rdy  mux       -> arbiter   downstream accepts the grant
//   req_ack  arbiter   -> requester one-cycle ack on acceptance
//   err      arbiter   -> monitor   request withdrawn before ack
// Modport master is the arbiter side, slave is the environment side.
interface rr_grant_arb_if #(
  parameter int CNT   = 5,
  parameter int IDX_W = 3
);
  logic [CNT-1:0]   req;
  logic [CNT-1:0]   gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             gnt_rdy;
  logic [CNT-1:0]   req_ack;
  logic             err;

  modport master (
    input  req, gnt_rdy,
    output gnt, gnt_idx, gnt_vld, req_ack, err
  );

  modport slave (
    output req, gnt_rdy,
    input  gnt, gnt_idx, gnt_vld, req_ack, err
  );
endinterface

// File: rtl/rr_grant_arb.sv
// rr_grant_arb: round-robin arbiter producing a registered one-hot grant
// plus binary index, held until the downstream stage accepts it.
// Ports:
//   clk  clock, all state on the rising edge
//   rst  asynchronous active-high reset
//   bus  rr_grant_arb_if.master (req, gnt_rdy in; gnt, gnt_idx, gnt_vld,
//        req_ack, err out)
// The priority pointer names the highest-priority requester and moves to
// one past the accepted requester, so continuous requests are served in
// strict rotation. Acceptance with pending requests re-arbitrates in the
// same cycle, giving one transfer per cycle.
module rr_grant_arb #(
  parameter int CNT   = 5,
  parameter int IDX_W = 3
) (
  input  logic          clk,
  input  logic          rst,
  rr_grant_arb_if.master bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic [CNT-1:0]   gnt_reg, gnt_next;
  logic [IDX_W-1:0] gnt_idx_reg, gnt_idx_next;
  logic             gnt_vld_reg, gnt_vld_next;
  logic             err_reg, err_next;

  logic [IDX_W-1:0] ptr_after;   // gnt_idx + 1 with a CNT (not 2**IDX_W) wrap
  logic [IDX_W-1:0] search_ptr;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [CNT-1:0]   win_onehot;
  logic [IDX_W:0]   cand_wide;
  logic [IDX_W-1:0] cand;

  assign ptr_after = (gnt_idx_reg == IDX_W'(CNT - 1)) ? '0 : gnt_idx_reg + 1'b1;

  // On an accept the search must already use the advanced pointer so the
  // next winner is loaded without a bubble.
  assign search_ptr = (state_reg == GRANT) ? ptr_after : ptr_reg;

  // Rotating priority search. Walking offsets from last to first lets the
  // lowest offset (closest to the pointer) overwrite any later match.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_wide = '0;
    cand      = '0;
    for (int off = CNT - 1; off >= 0; off--) begin
      cand_wide = {1'b0, search_ptr} + (IDX_W+1)'(off);
      if (cand_wide >= (IDX_W+1)'(CNT))
        cand_wide = cand_wide - (IDX_W+1)'(CNT);
      cand = cand_wide[IDX_W-1:0];
      if (bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CNT; gi++) begin : g_onehot
      assign win_onehot[gi] = win_found && (win_idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      gnt_reg     <= '0;
      gnt_idx_reg <= '0;
      gnt_vld_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      gnt_reg     <= gnt_next;
      gnt_idx_reg <= gnt_idx_next;
      gnt_vld_reg <= gnt_vld_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    gnt_next     = gnt_reg;
    gnt_idx_next = gnt_idx_reg;
    gnt_vld_next = gnt_vld_reg;
    err_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          gnt_next     = win_onehot;
          gnt_idx_next = win_idx;
          gnt_vld_next = 1'b1;
          state_next   = GRANT;
        end
      end
      GRANT: begin
        // A requester dropping its line before the ack is flagged, but the
        // grant is still held until the downstream stage takes it.
        err_next = !bus.gnt_rdy && !bus.req[gnt_idx_reg];
        if (bus.gnt_rdy) begin
          ptr_next = ptr_after;
          if (win_found) begin
            gnt_next     = win_onehot;
            gnt_idx_next = win_idx;
          end else begin
            gnt_next     = '0;
            gnt_idx_next = '0;
            gnt_vld_next = 1'b0;
            state_next   = IDLE;
          end
        end
      end
      default: begin
        state_next   = IDLE;
        gnt_next     = '0;
        gnt_idx_next = '0;
        gnt_vld_next = 1'b0;
      end
    endcase
  end

  assign bus.gnt     = gnt_reg;
  assign bus.gnt_idx = gnt_idx_reg;
  assign bus.gnt_vld = gnt_vld_reg;
  assign bus.err     = err_reg;
  assign bus.req_ack = gnt_reg & {CNT{gnt_vld_reg & bus.gnt_rdy}};

endmodule

// File: tb/tb_rr_grant_arb.sv
// tb_rr_grant_arb: directed, table-driven bench for rr_grant_arb (CNT=5).
// Each table row gives the inputs for one cycle, the req_ack expected in
// that cycle (before the edge) and the registered outputs expected after it.
module tb_rr_grant_arb;

  localparam int CNT   = 5;
  localparam int IDX_W = 3;
  localparam int NVEC  = 30;

  logic clk;
  logic rst;

  rr_grant_arb_if #(.CNT(CNT), .IDX_W(IDX_W)) bus ();

  rr_grant_arb #(.CNT(CNT), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CNT-1:0]   req;
    logic             rdy;
    logic [CNT-1:0]   ack;
    logic [CNT-1:0]   gnt;
    logic [IDX_W-1:0] idx;
    logic             vld;
    logic             err;
  } vec_t;

  vec_t vecs [NVEC];
  int n_cmp;
  int n_bad;

  function automatic vec_t mk(logic [CNT-1:0] req, logic rdy, logic [CNT-1:0] ack,
                              logic [CNT-1:0] gnt, logic [IDX_W-1:0] idx,
                              logic vld, logic err);
    vec_t v;
    v.req = req; v.rdy = rdy; v.ack = ack;
    v.gnt = gnt; v.idx = idx; v.vld = vld; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input int step, input vec_t v);
    chk({tag, ".gnt"},     step, 32'(bus.gnt),     32'(v.gnt));
    chk({tag, ".gnt_idx"}, step, 32'(bus.gnt_idx), 32'(v.idx));
    chk({tag, ".gnt_vld"}, step, 32'(bus.gnt_vld), 32'(v.vld));
    chk({tag, ".err"},     step, 32'(bus.err),     32'(v.err));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    //            req       rdy   ack(pre)  gnt(post) idx vld err
    // Full-request rotation from ptr=0
    vecs[0]  = mk(5'b11111, 1'b1, 5'b00000, 5'b00001, 3'd0, 1'b1, 1'b0);
    vecs[1]  = mk(5'b11111, 1'b1, 5'b00001, 5'b00010, 3'd1, 1'b1, 1'b0);
    vecs[2]  = mk(5'b11111, 1'b1, 5'b00010, 5'b00100, 3'd2, 1'b1, 1'b0);
    vecs[3]  = mk(5'b11111, 1'b1, 5'b00100, 5'b01000, 3'd3, 1'b1, 1'b0);
    vecs[4]  = mk(5'b11111, 1'b1, 5'b01000, 5'b10000, 3'd4, 1'b1, 1'b0);
    vecs[5]  = mk(5'b11111, 1'b1, 5'b10000, 5'b00001, 3'd0, 1'b1, 1'b0);
    vecs[6]  = mk(5'b11111, 1'b1, 5'b00001, 5'b00010, 3'd1, 1'b1, 1'b0);
    vecs[7]  = mk(5'b00000, 1'b1, 5'b00010, 5'b00000, 3'd0, 1'b0, 1'b0); // ptr=2
    // Single requester held: re-granted every cycle
    vecs[8]  = mk(5'b00100, 1'b1, 5'b00000, 5'b00100, 3'd2, 1'b1, 1'b0);
    vecs[9]  = mk(5'b00100, 1'b1, 5'b00100, 5'b00100, 3'd2, 1'b1, 1'b0);
    vecs[10] = mk(5'b00100, 1'b1, 5'b00100, 5'b00100, 3'd2, 1'b1, 1'b0);
    vecs[11] = mk(5'b00000, 1'b1, 5'b00100, 5'b00000, 3'd0, 1'b0, 1'b0); // ptr=3
    // Bring ptr to 0 via a grant to 4
    vecs[12] = mk(5'b10000, 1'b0, 5'b00000, 5'b10000, 3'd4, 1'b1, 1'b0);
    vecs[13] = mk(5'b00000, 1'b1, 5'b10000, 5'b00000, 3'd0, 1'b0, 1'b0); // ptr=0
    // Stall: 10001 held 4 cycles with rdy=0
    vecs[14] = mk(5'b10001, 1'b0, 5'b00000, 5'b00001, 3'd0, 1'b1, 1'b0);
    vecs[15] = mk(5'b10001, 1'b0, 5'b00000, 5'b00001, 3'd0, 1'b1, 1'b0);
    vecs[16] = mk(5'b10001, 1'b0, 5'b00000, 5'b00001, 3'd0, 1'b1, 1'b0);
    vecs[17] = mk(5'b10001, 1'b0, 5'b00000, 5'b00001, 3'd0, 1'b1, 1'b0);
    vecs[18] = mk(5'b10001, 1'b0, 5'b00000, 5'b00001, 3'd0, 1'b1, 1'b0);
    vecs[19] = mk(5'b10001, 1'b1, 5'b00001, 5'b10000, 3'd4, 1'b1, 1'b0);
    vecs[20] = mk(5'b00000, 1'b1, 5'b10000, 5'b00000, 3'd0, 1'b0, 1'b0); // ptr=0
    // Wrap: grant 3, then ptr=4 with 01001 -> 0 wins, then ptr=1 -> 3
    vecs[21] = mk(5'b01000, 1'b0, 5'b00000, 5'b01000, 3'd3, 1'b1, 1'b0);
    vecs[22] = mk(5'b01001, 1'b1, 5'b01000, 5'b00001, 3'd0, 1'b1, 1'b0);
    vecs[23] = mk(5'b01001, 1'b1, 5'b00001, 5'b01000, 3'd3, 1'b1, 1'b0);
    vecs[24] = mk(5'b00000, 1'b1, 5'b01000, 5'b00000, 3'd0, 1'b0, 1'b0); // ptr=4
    // Withdrawal of req[1] for one cycle while stalled
    vecs[25] = mk(5'b00010, 1'b0, 5'b00000, 5'b00010, 3'd1, 1'b1, 1'b0);
    vecs[26] = mk(5'b00000, 1'b0, 5'b00000, 5'b00010, 3'd1, 1'b1, 1'b1);
    vecs[27] = mk(5'b00010, 1'b0, 5'b00000, 5'b00010, 3'd1, 1'b1, 1'b0);
    vecs[28] = mk(5'b00000, 1'b1, 5'b00010, 5'b00000, 3'd0, 1'b0, 1'b0); // ptr=2
    // Set up a grant for the async reset check
    vecs[29] = mk(5'b11111, 1'b0, 5'b00000, 5'b00100, 3'd2, 1'b1, 1'b0);

    // Reset state
    rst = 1'b1;
    bus.req = '0;
    bus.gnt_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.gnt",     -1, 32'(bus.gnt),     32'd0);
    chk("rst.gnt_idx", -1, 32'(bus.gnt_idx), 32'd0);
    chk("rst.gnt_vld", -1, 32'(bus.gnt_vld), 32'd0);
    chk("rst.err",     -1, 32'(bus.err),     32'd0);
    chk("rst.req_ack", -1, 32'(bus.req_ack), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      bus.req = vecs[i].req;
      bus.gnt_rdy = vecs[i].rdy;
      #1;
      chk("vec.req_ack", i, 32'(bus.req_ack), 32'(vecs[i].ack));
      @(posedge clk);
      #1;
      chk_regs("vec", i, vecs[i]);
      $display("step %0d req=%b rdy=%b -> gnt=%b idx=%0d vld=%b err=%b",
               i, vecs[i].req, vecs[i].rdy, bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.err);
    end

    // Async reset pulse mid-grant, well away from any clock edge
    #2;
    rst = 1'b1;
    #1;
    chk("arst.gnt",     100, 32'(bus.gnt),     32'd0);
    chk("arst.gnt_vld", 100, 32'(bus.gnt_vld), 32'd0);
    chk("arst.gnt_idx", 100, 32'(bus.gnt_idx), 32'd0);
    chk("arst.req_ack", 100, 32'(bus.req_ack), 32'd0);
    #1;
    rst = 1'b0;
    bus.req = 5'b11111;
    bus.gnt_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("arst.first_gnt", 101, 32'(bus.gnt),     32'b00001);
    chk("arst.first_idx", 101, 32'(bus.gnt_idx), 32'd0);
    chk("arst.first_vld", 101, 32'(bus.gnt_vld), 32'd1);
    $display("post-reset grant gnt=%b idx=%0d", bus.gnt, bus.gnt_idx);
    @(posedge clk);
    #1;
    chk("arst.second_idx", 102, 32'(bus.gnt_idx), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
